// File: rtl/uart_tx_framed.sv
// UART transmitter: start, LSB-first data, optional parity, 1-2 stop bits.
// Define UART_TX_PARITY_EN to add the parity bit (PARITY_ODD picks sense).
module uart_tx_framed #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 100,
   parameter int STOP_BITS    = 1,
   parameter int START_DELAY  = 0,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 send,
   output logic                 ready,
   output logic                 busy,
   output logic                 txOut,
   output logic                 sendSig,
   output logic                 done
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int CMAX =
      (DATA_BITS > START_DELAY) ? DATA_BITS : START_DELAY;
   localparam int CW = $clog2(CMAX + 1);
   localparam int LEAD_LAST = (START_DELAY > 0) ? START_DELAY - 1 : 0;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE, LEAD, START, DATA, PARITY, STOP
   } state_t;
   logic parBit;
`else
   typedef enum logic [2:0] {
      IDLE, LEAD, START, DATA, STOP
   } state_t;
`endif

   state_t               state;
   state_t               stateNext;
   logic [TW-1:0]        timer;
   logic [CW-1:0]        cnt;
   logic [DATA_BITS-1:0] shift;
   logic [DATA_BITS-1:0] shiftNext;
   logic                 txNext;
   logic                 tick;
   logic                 accept;

   assign tick   = (timer == TW'(CLKS_PER_BIT - 1));
   assign accept = (state == IDLE) && send;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         timer <= '0;
         cnt   <= '0;
         shift <= '0;
         txOut <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parBit <= 1'b0;
`endif
      end else begin
         state <= stateNext;
         shift <= shiftNext;
         txOut <= txNext;
         if (state == IDLE || tick)
            timer <= '0;
         else
            timer <= timer + 1'b1;
         // cnt counts lead, data or stop periods of the current state
         if (stateNext != state)
            cnt <= '0;
         else if (tick)
            cnt <= cnt + 1'b1;
`ifdef UART_TX_PARITY_EN
         if (accept)
            parBit <= (^data) ^ (PARITY_ODD != 0);
`endif
      end
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:
            if (send)
               stateNext = (START_DELAY > 0) ? LEAD : START;
         LEAD:
            if (tick && cnt == CW'(LEAD_LAST))
               stateNext = START;
         START:
            if (tick)
               stateNext = DATA;
         DATA:
            if (tick && cnt == CW'(DATA_BITS - 1))
`ifdef UART_TX_PARITY_EN
               stateNext = PARITY;
         PARITY:
            if (tick)
               stateNext = STOP;
`else
               stateNext = STOP;
`endif
         STOP:
            if (tick && cnt == CW'(STOP_BITS - 1))
               stateNext = IDLE;
         default:
            stateNext = IDLE;
      endcase
   end

   always_comb begin
      shiftNext = shift;
      if (accept)
         shiftNext = data;
      else if (state == DATA && tick)
         shiftNext = shift >> 1;

      // line level is registered, so it follows the upcoming state
      txNext = 1'b1;
      unique case (stateNext)
         START:   txNext = 1'b0;
         DATA:    txNext = shiftNext[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  txNext = parBit;
`endif
         default: txNext = 1'b1;
      endcase

      ready   = (state == IDLE);
      busy    = (state != IDLE);
      sendSig = (state == START) && (timer == '0);
      done    = (state == STOP) && tick &&
                (cnt == CW'(STOP_BITS - 1));
   end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: three configurations checked cycle by cycle
// against an expected frame computed from the bit-level framing rules.
module tb_uart_tx_framed;

   localparam int C = 4;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   int dly [3];
   int stp [3];
   int odd [3];

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data [3];
   logic [2:0] send = '0;
   logic [2:0] ready, busy, txOut, sendSig, done;

   int nPass = 0;
   int nChecks = 0;
   int cyc = 0;
   int lastSS [3];

   always #5 clk = ~clk;

   uart_tx_framed #(.DATA_BITS(8), .CLKS_PER_BIT(C), .STOP_BITS(1),
      .START_DELAY(0), .PARITY_ODD(0)) dut0 (
      .clk(clk), .reset(reset), .data(data[0]), .send(send[0]),
      .ready(ready[0]), .busy(busy[0]), .txOut(txOut[0]),
      .sendSig(sendSig[0]), .done(done[0]));

   uart_tx_framed #(.DATA_BITS(8), .CLKS_PER_BIT(C), .STOP_BITS(2),
      .START_DELAY(2), .PARITY_ODD(1)) dut1 (
      .clk(clk), .reset(reset), .data(data[1]), .send(send[1]),
      .ready(ready[1]), .busy(busy[1]), .txOut(txOut[1]),
      .sendSig(sendSig[1]), .done(done[1]));

   uart_tx_framed #(.DATA_BITS(8), .CLKS_PER_BIT(C), .STOP_BITS(2),
      .START_DELAY(0), .PARITY_ODD(0)) dut2 (
      .clk(clk), .reset(reset), .data(data[2]), .send(send[2]),
      .ready(ready[2]), .busy(busy[2]), .txOut(txOut[2]),
      .sendSig(sendSig[2]), .done(done[2]));

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) nPass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic int frameBits(input int i);
      return 1 + 8 + P + stp[i];
   endfunction

   // expected line level k cycles after the accept cycle
   function automatic logic expBit(input int i, input logic [7:0] v,
                                   input int k);
      int b;
      b = (k - 1) / C - dly[i];
      if (b < 0) return 1'b1;
      if (b == 0) return 1'b0;
      if (b <= 8) return v[b-1];
      if (P == 1 && b == 9) return (^v) ^ odd[i][0];
      return 1'b1;
   endfunction

   task automatic checkIdle(input int i, input string tag);
      check($sformatf("%s_ready%0d", tag, i), ready[i], 1);
      check($sformatf("%s_busy%0d", tag, i), busy[i], 0);
      check($sformatf("%s_tx%0d", tag, i), txOut[i], 1);
      check($sformatf("%s_ss%0d", tag, i), sendSig[i], 0);
      check($sformatf("%s_done%0d", tag, i), done[i], 0);
   endtask

   task automatic sendFrame(input int i, input logic [7:0] v,
                            input bit hold, input logic [7:0] nxt,
                            input int glitchAt, input int abortAt);
      int len;
      len = (dly[i] + frameBits(i)) * C;
      check($sformatf("pre_ready%0d", i), ready[i], 1);
      data[i] = v;
      send[i] = 1'b1;
      step();
      send[i] = hold;
      if (hold) data[i] = nxt;
      for (int k = 1; k <= len; k++) begin
         if (k == abortAt) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            checkIdle(i, "abort");
            return;
         end
         if (k == glitchAt) begin
            send[i] = 1'b1;
            data[i] = 8'hFF;
         end else if (!hold && k == glitchAt + 1) begin
            send[i] = 1'b0;
         end
         check($sformatf("tx%0d_v%0h_k%0d", i, v, k),
               txOut[i], expBit(i, v, k));
         check($sformatf("ss%0d_k%0d", i, k),
               sendSig[i], (k == dly[i] * C + 1));
         check($sformatf("done%0d_k%0d", i, k), done[i], (k == len));
         check($sformatf("busy%0d_k%0d", i, k), busy[i], 1);
         if (sendSig[i]) lastSS[i] = cyc;
         step();
      end
      check($sformatf("post_ready%0d", i), ready[i], 1);
      check($sformatf("post_busy%0d", i), busy[i], 0);
      check($sformatf("post_tx%0d", i), txOut[i], 1);
   endtask

   initial begin
      int s1;
      logic [7:0] r;
      dly = '{0, 2, 0};
      stp = '{1, 2, 2};
      odd = '{0, 1, 0};
      for (int i = 0; i < 3; i++) data[i] = 8'h00;

      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) checkIdle(i, "rst");

      sendFrame(0, 8'hA5, 0, 8'h00, 0, 0);
      sendFrame(0, 8'hA5, 0, 8'h00, 10, 0);
      sendFrame(0, 8'hA5, 0, 8'h00, 0, 18);
      step();
      checkIdle(0, "after_abort");
      sendFrame(0, 8'h3C, 0, 8'h00, 0, 0);

      sendFrame(2, 8'h01, 1, 8'h80, 0, 0);
      s1 = lastSS[2];
      sendFrame(2, 8'h80, 0, 8'h00, 0, 0);
      check("b2b_gap", lastSS[2] - s1, frameBits(2) * C + 1);

      sendFrame(1, 8'hA5, 0, 8'h00, 0, 0);

      reset = 1'b1;
      send[0] = 1'b1;
      data[0] = 8'h55;
      step();
      reset = 1'b0;
      send[0] = 1'b0;
      checkIdle(0, "rst_send");
      step();
      checkIdle(0, "rst_send2");

      for (int n = 0; n < 6; n++) begin
         r = 8'($urandom);
         sendFrame(n % 2, r, 0, 8'h00, 0, 0);
         step();
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/uart_tx_framed.md
# uart_tx_framed

Parametrised UART transmitter that serialises one parallel word per request into a standard asynchronous frame: start bit, data bits LSB first, optional parity, then one or two stop bits. The bit clock comes from an internal divider, not a derived clock. It provides a valid/ready request handshake, a busy flag, a done pulse and a start strobe for the matching receiver. It sits between game-logic message builders and the board-to-board serial link.

## Interface
- `DATA_BITS`, 8, data bits per frame; legal range 5..16.
- `CLKS_PER_BIT`, 100, `clk` cycles per serial bit period; minimum 2.
- `STOP_BITS`, 1, stop bits per frame; 1 or 2.
- `START_DELAY`, 0, idle-high bit periods inserted between accept and the start bit; gives receiver propagation slack.
- `PARITY_ODD`, 0, parity sense: 0 even, 1 odd. Only used when `UART_TX_PARITY_EN` is defined.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data`  in  `DATA_BITS`  word to send; sampled only on accept.
- `send`  in  1  request; a frame is accepted on a cycle with `send && ready`.
- `ready`  out  1  high only in IDLE; combinational from state.
- `busy`  out  1  high from the cycle after accept until the return to IDLE.
- `txOut`  out  1  serial line, registered, idles high.
- `sendSig`  out  1  one-cycle strobe in the first cycle the start bit is on `txOut`.
- `done`  out  1  one-cycle strobe in the last cycle of the final stop bit.

## Operation
- States: IDLE, LEAD, START, DATA, PARITY, STOP.
- IDLE: `txOut`=1. On accept, latch `data` into the shift register, clear the bit timer and bit counter, then go to LEAD if `START_DELAY`>0, else START.
- LEAD: `txOut`=1 for `START_DELAY` bit periods, then go to START.
- START: `txOut`=0 for one bit period, then go to DATA.
- DATA: `txOut`=shift[0]. At the end of each bit period, shift right and increment the bit counter. After `DATA_BITS` bits, go to PARITY if enabled, else STOP.
- PARITY: `txOut`=parity bit for one period, then go to STOP.
- STOP: `txOut`=1 for `STOP_BITS` periods, then go to IDLE.
- Bit timer counts 0..`CLKS_PER_BIT`-1. A state or bit advances when the timer reaches `CLKS_PER_BIT`-1. Timer width is $clog2(`CLKS_PER_BIT`).
- Frame length F = 1 + `DATA_BITS` + P + `STOP_BITS` bit periods, where P = 1 if parity is enabled, else 0.
- `send` while busy is ignored, with no queueing. `data` changes after accept have no effect on the frame in flight.
- Reset at any time, including mid-frame: the frame is abandoned. The next cycle shows IDLE, `txOut`=1, `busy`=0, `ready`=1, `sendSig`=0, `done`=0. No partial stop bit is sent.
- Reset values: `txOut`=1, `busy`=0, `sendSig`=0, `done`=0, `ready`=1.

## Timing
- Accept in cycle N. With `START_DELAY`=D, `txOut` is high for cycles N+1..N+D·`CLKS_PER_BIT`.
- The start bit is low from cycle N+1+D·`CLKS_PER_BIT`, and `sendSig` pulses in that same cycle.
- Every bit is held exactly `CLKS_PER_BIT` cycles.
- `done` pulses in cycle N+(D+F)·`CLKS_PER_BIT`. `ready` is high in the following cycle.
- Back-to-back requests with `send` held high start a new frame every (D+F)·`CLKS_PER_BIT`+1 cycles. The extra cycle lengthens the final stop bit by one `clk` cycle.
- If `reset` and `send` are both high in the same cycle, reset wins and nothing is accepted.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state exists and P=1.
  - Even parity (`PARITY_ODD`=0): bit = XOR of the data bits.
  - Odd parity (`PARITY_ODD`=1): bit = the inverse of that XOR.
- `UART_TX_PARITY_EN` undefined: the PARITY state and its logic are removed, P=0, and `PARITY_ODD` is ignored.

## Test plan
- 8N1, `CLKS_PER_BIT`=4, send 0xA5 -> `txOut` bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. `sendSig` pulses at N+1, `done` at N+40, `ready` is high at N+41.
- `UART_TX_PARITY_EN`, `PARITY_ODD`=0, send 0xA5 -> parity bit 0. With `PARITY_ODD`=1, parity bit 1. Frame is 11 bit periods.
- `send` pulsed again with 0xFF mid-frame -> ignored; the 0xA5 frame completes unchanged and `busy` stays high throughout.
- `reset` asserted during DATA bit 3 -> the next cycle shows `txOut`=1, `busy`=0, `ready`=1. A new send of 0x3C then produces a full, correct frame.
- `send` held high with 0x01 then 0x80, `STOP_BITS`=2 -> two frames whose start bits are (F·4+1) cycles apart, each with two full stop bits.
- `START_DELAY`=2, `CLKS_PER_BIT`=4 -> `txOut` stays high for 8 cycles after accept, and the start bit with `sendSig` appears at N+9.
